link_poll_scheduler: RTL and testbench

LINK_POLL_SCHEDULER -- requirements
Module: link_poll_scheduler

---
 rtl/link_sched_pkg.sv | 19 +
 rtl/rr_pick.sv | 35 +++
 rtl/link_poll_scheduler.sv | 153 +++++++++++++++
 tb/tb_link_poll_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_sched_pkg.sv
// Shared definitions for the serial-link poll scheduler: FSM states,
// default link count and the per-link miss counter width.
package link_sched_pkg;

    localparam int NCH_DEFAULT = 4;

    // Wide enough for any MAX_MISS up to 15.
    localparam int MISS_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WAIT_IDLE,
        START,
        WAIT_RESP,
        NEXT
    } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: the lowest set mask bit strictly above last_idx,
// otherwise the lowest set bit overall (flagged as a wrap).
module rr_pick #(
    parameter int NCH   = 4,
    parameter int IDX_W = 2
) (
    input  logic [NCH-1:0]   mask,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] next_idx,
    output logic             wrap
);

    logic             found_above;
    logic [IDX_W-1:0] above_idx;
    logic [IDX_W-1:0] low_idx;

    // Scanning downward leaves the lowest qualifying index in each result.
    always_comb begin
        found_above = 1'b0;
        above_idx   = '0;
        low_idx     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = IDX_W'(i);
                if (i > int'(last_idx)) begin
                    above_idx   = IDX_W'(i);
                    found_above = 1'b1;
                end
            end
        end
        next_idx = found_above ? above_idx : low_idx;
        wrap     = !found_above;
    end

endmodule

// File: rtl/link_poll_scheduler.sv
// Polls serial links one at a time in round-robin order, times out silent
// links and flags any link that misses MAX_MISS consecutive polls.
module link_poll_scheduler
    import link_sched_pkg::*;
#(
    parameter int NCH         = NCH_DEFAULT,
    parameter int TIMEOUT_CYC = 50000,
    parameter int MAX_MISS    = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [NCH-1:0]          chan_mask,
    input  logic [NCH-1:0]          tx_busy,
    input  logic [NCH-1:0]          rx_frame_done,
    input  logic [NCH-1:0]          check_sum_error,
    output logic [NCH-1:0]          tx_start,
    output logic [$clog2(NCH)-1:0]  cur_chan,
    output logic [NCH-1:0]          comNoResponse,
    output logic                    cycle_done
);

    localparam int IDX_W = $clog2(NCH);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TMR_W-1:0]  TIMER_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [MISS_W-1:0] MISS_LIM   = MISS_W'(MAX_MISS);

    sched_state_t state, state_next;

    logic [TMR_W-1:0]             timer;
    logic [NCH-1:0][MISS_W-1:0]   miss_cnt;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_wrap;

    logic sel_load;
    logic fire;
    logic frame_good;
    logic poll_miss;

    rr_pick #(
        .NCH   (NCH),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .mask     (chan_mask),
        .last_idx (cur_chan),
        .next_idx (pick_idx),
        .wrap     (pick_wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A frame landing in the same cycle as timer expiry wins over the timeout.
    always_comb begin
        state_next = state;
        sel_load   = 1'b0;
        fire       = 1'b0;
        frame_good = 1'b0;
        poll_miss  = 1'b0;
        cycle_done = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (|chan_mask)) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                if (|chan_mask) begin
                    sel_load   = 1'b1;
                    state_next = WAIT_IDLE;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!tx_busy[cur_chan]) begin
                    fire       = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (rx_frame_done[cur_chan]) begin
                    frame_good = !check_sum_error[cur_chan];
                    poll_miss  = check_sum_error[cur_chan];
                    state_next = NEXT;
                end else if (timer == '0) begin
                    poll_miss  = 1'b1;
                    state_next = NEXT;
                end
            end
            NEXT: begin
                cycle_done = pick_wrap;
                state_next = enable ? SELECT : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // tx_start is registered off the WAIT_IDLE decision so it is high during START.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_chan <= IDX_W'(NCH - 1);
            tx_start <= '0;
        end else begin
            tx_start <= fire ? (NCH'(1) << cur_chan) : '0;
            if (sel_load) begin
                cur_chan <= pick_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (state == START) begin
            timer <= TIMER_LOAD;
        end else if ((state == WAIT_RESP) && (timer != '0)) begin
            timer <= timer - TMR_W'(1);
        end
    end

    // The flag rises on the miss that brings the count to MAX_MISS and is
    // only cleared by a good frame from that link.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miss_cnt      <= '0;
            comNoResponse <= '0;
        end else if (frame_good) begin
            miss_cnt[cur_chan]      <= '0;
            comNoResponse[cur_chan] <= 1'b0;
        end else if (poll_miss) begin
            if (miss_cnt[cur_chan] < MISS_LIM) begin
                miss_cnt[cur_chan] <= miss_cnt[cur_chan] + MISS_W'(1);
            end
            if (miss_cnt[cur_chan] >= (MISS_LIM - MISS_W'(1))) begin
                comNoResponse[cur_chan] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_link_poll_scheduler.sv
// Scoreboard bench for link_poll_scheduler: expected tx_start / cycle_done
// events are queued by the stimulus and popped by an independent monitor.
module tb_link_poll_scheduler;

    localparam int NCH         = 4;
    localparam int TIMEOUT_CYC = 20;
    localparam int MAX_MISS    = 3;
    localparam int WAIT_BUDGET = 200;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic [NCH-1:0]   chan_mask;
    logic [NCH-1:0]   tx_busy;
    logic [NCH-1:0]   rx_frame_done;
    logic [NCH-1:0]   check_sum_error;
    logic [NCH-1:0]   tx_start;
    logic [1:0]       cur_chan;
    logic [NCH-1:0]   comNoResponse;
    logic             cycle_done;

    int checks = 0;
    int errors = 0;

    int exp_tx[$];
    int exp_cd[$];

    int reply_delay[NCH];
    int bad_total[NCH];
    int bad_used[NCH];
    int spur_ch;
    int resp_cnt;
    int resp_ch;
    int spur_cnt;
    logic resp_bad;

    always #5 clk = ~clk;

    link_poll_scheduler #(
        .NCH         (NCH),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MAX_MISS    (MAX_MISS)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .chan_mask       (chan_mask),
        .tx_busy         (tx_busy),
        .rx_frame_done   (rx_frame_done),
        .check_sum_error (check_sum_error),
        .tx_start        (tx_start),
        .cur_chan        (cur_chan),
        .comNoResponse   (comNoResponse),
        .cycle_done      (cycle_done)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [NCH-1:0] mask);
        @(negedge clk);
        enable    = en;
        chan_mask = mask;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        enable    = 1'b0;
        chan_mask = '0;
        tx_busy   = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_tx(input int ch, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!tx_start[ch] && cycles < WAIT_BUDGET);
        if (!tx_start[ch]) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_tx%0d: no tx_start within %0d cycles, expected one", ch, cycles);
        end
    endtask

    // Link model: replies reply_delay cycles after tx_start (0 = never),
    // the first bad_total replies carrying a checksum error; a silent link
    // triggers a stray frame on spur_ch that the scheduler must ignore.
    initial begin
        rx_frame_done   = '0;
        check_sum_error = '0;
        resp_cnt = 0;
        resp_ch  = 0;
        spur_cnt = 0;
        resp_bad = 1'b0;
        for (int c = 0; c < NCH; c++) bad_used[c] = 0;
        forever begin
            @(negedge clk);
            rx_frame_done   = '0;
            check_sum_error = '0;
            if (!reset_n) begin
                resp_cnt = 0;
                spur_cnt = 0;
                for (int c = 0; c < NCH; c++) bad_used[c] = 0;
            end else begin
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        rx_frame_done[resp_ch]   = 1'b1;
                        check_sum_error[resp_ch] = resp_bad;
                    end
                end
                if (spur_cnt > 0) begin
                    spur_cnt--;
                    if (spur_cnt == 0 && spur_ch >= 0) rx_frame_done[spur_ch] = 1'b1;
                end
                for (int c = 0; c < NCH; c++) begin
                    if (tx_start[c]) begin
                        if (reply_delay[c] > 0) begin
                            resp_cnt = reply_delay[c];
                            resp_ch  = c;
                            resp_bad = (bad_used[c] < bad_total[c]);
                            if (resp_bad) bad_used[c]++;
                        end else begin
                            spur_cnt = 3;
                        end
                    end
                end
            end
        end
    end

    // Monitor: every tx_start / cycle_done pulse must match the queue head.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (tx_start != '0) begin
                    if (exp_tx.size() == 0) begin
                        checkOutput("tx_unexpected", int'(tx_start), 0);
                    end else begin
                        e = exp_tx.pop_front();
                        checkOutput("tx_order", int'(tx_start), 1 << e);
                    end
                end
                if (cycle_done) begin
                    if (exp_cd.size() == 0) begin
                        checkOutput("cycle_done_unexpected", int'(cycle_done), 0);
                    end else begin
                        e = exp_cd.pop_front();
                        checkOutput("cycle_done_chan", int'(cur_chan), e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [NCH-1:0] seen;

        reset_n   = 1'b0;
        enable    = 1'b0;
        chan_mask = '0;
        tx_busy   = '0;
        spur_ch   = -1;
        for (int c = 0; c < NCH; c++) begin
            reply_delay[c] = 5;
            bad_total[c]   = 0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("reset_tx_start", int'(tx_start), 0);
        checkOutput("reset_cur_chan", int'(cur_chan), 3);
        checkOutput("reset_no_resp", int'(comNoResponse), 0);
        checkOutput("reset_cycle_done", int'(cycle_done), 0);
        reset_n = 1'b1;

        // Full rotation with prompt replies, plus start latency
        $display("[TB] rotation mask=1111");
        exp_tx.push_back(0); exp_tx.push_back(1); exp_tx.push_back(2);
        exp_tx.push_back(3); exp_tx.push_back(0);
        exp_cd.push_back(3);
        applyStimulus(1'b1, 4'b1111);
        repeat (3) @(negedge clk);
        checkOutput("start_latency", int'(tx_start), 1);
        wait_tx(1, n);
        wait_tx(2, n);
        wait_tx(3, n);
        wait_tx(0, n);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("rotation_no_resp", int'(comNoResponse), 0);

        // Two checksum errors then a good frame on link 1
        $display("[TB] checksum errors on link 1");
        do_reset();
        bad_total[1] = 2;
        for (int k = 0; k < 3; k++) begin
            exp_tx.push_back(1);
            exp_cd.push_back(1);
        end
        applyStimulus(1'b1, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            wait_tx(1, n);
            if (k == 2) enable = 1'b0;
            repeat (7) @(negedge clk);
            checkOutput("miss_cnt1", int'(dut.miss_cnt[1]), (k == 2) ? 0 : k + 1);
            checkOutput("cse_no_flag1", int'(comNoResponse[1]), 0);
        end
        bad_total[1] = 0;

        // Transmitter busy holds off tx_start
        $display("[TB] busy link 0");
        do_reset();
        exp_tx.push_back(0);
        exp_cd.push_back(0);
        tx_busy = 4'b0001;
        applyStimulus(1'b1, 4'b0001);
        seen = '0;
        repeat (10) begin
            @(negedge clk);
            seen |= tx_start;
        end
        checkOutput("busy_hold", int'(seen), 0);
        tx_busy = '0;
        @(negedge clk);
        checkOutput("busy_release", int'(tx_start), 1);
        enable = 1'b0;
        repeat (20) @(negedge clk);

        // Silent link 2 with stray frames on link 0 while link 2 is polled
        $display("[TB] silent link 2 mask=0101");
        do_reset();
        reply_delay[2] = 0;
        spur_ch        = 0;
        exp_tx.push_back(0);
        for (int k = 0; k < 3; k++) begin
            exp_tx.push_back(2);
            exp_tx.push_back(0);
            exp_cd.push_back(2);
        end
        applyStimulus(1'b1, 4'b0101);
        wait_tx(0, n);
        for (int k = 0; k < 3; k++) begin
            wait_tx(2, n);
            wait_tx(0, n);
            if (k == 2) enable = 1'b0;
            if (k == 0) checkOutput("timeout_period", n, TIMEOUT_CYC + 4);
            checkOutput("no_resp_flag2", int'(comNoResponse[2]), (k == 2) ? 1 : 0);
            checkOutput("no_resp_flag0", int'(comNoResponse[0]), 0);
        end
        repeat (20) @(negedge clk);

        // Asynchronous reset in the middle of a poll
        $display("[TB] reset during WAIT_RESP");
        exp_tx.push_back(2);
        applyStimulus(1'b1, 4'b0101);
        wait_tx(2, n);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        checkOutput("async_tx_start", int'(tx_start), 0);
        checkOutput("async_cur_chan", int'(cur_chan), 3);
        checkOutput("async_no_resp", int'(comNoResponse), 0);
        checkOutput("async_cycle_done", int'(cycle_done), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_tx.push_back(0);
        applyStimulus(1'b1, 4'b0101);
        wait_tx(0, n);
        enable = 1'b0;
        repeat (20) @(negedge clk);

        // Reply arriving exactly as the timer reaches zero
        $display("[TB] reply coincident with timeout");
        do_reset();
        reply_delay[2] = 5;
        spur_ch        = -1;
        reply_delay[0] = TIMEOUT_CYC;
        for (int k = 0; k < 3; k++) begin
            exp_tx.push_back(0);
            exp_cd.push_back(0);
        end
        applyStimulus(1'b1, 4'b0001);
        wait_tx(0, n);
        wait_tx(0, n);
        checkOutput("coincide_period", n, TIMEOUT_CYC + 4);
        checkOutput("coincide_miss_cnt", int'(dut.miss_cnt[0]), 0);
        wait_tx(0, n);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("coincide_miss_final", int'(dut.miss_cnt[0]), 0);
        checkOutput("coincide_flag", int'(comNoResponse[0]), 0);

        checkOutput("tx_queue_drained", exp_tx.size(), 0);
        checkOutput("cd_queue_drained", exp_cd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
